// File: rtl/kanagawa_loop_collector.sv
// Collapses the per-thread entries of one pipelined call into a single entry whose ACC field
// holds the sum over all threads. Optional thread-order checking: KANAGAWA_LOOP_COLLECTOR_SEQ_CHECK_EN.
module kanagawa_loop_collector #(
  parameter int unsigned TOTAL_WIDTH               = 16,
  parameter int unsigned COUNTER_WIDTH             = 4,
  parameter int unsigned HAS_LITERAL_MAX_THREAD_ID = 1,
  parameter int unsigned LITERAL_MAX_THREAD_ID     = 3,
  parameter int unsigned OFFSET                    = 0,
  parameter int unsigned MAX_OFFSET                = 4,
  parameter int unsigned ACC_OFFSET                = 8,
  parameter int unsigned ACC_WIDTH                 = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   empty_in,
  input  logic [TOTAL_WIDTH-1:0] data_in,
  output logic                   rden_out,
  output logic [TOTAL_WIDTH-1:0] data_out,
  output logic                   empty_out,
  input  logic                   rden_in,
  output logic                   seq_error_out,
  output logic                   underflow_out
);

  logic                     out_valid_q, out_valid_d;
  logic [TOTAL_WIDTH-1:0]   out_data_q, out_data_d;
  logic [ACC_WIDTH-1:0]     acc_q, acc_d;
  logic [COUNTER_WIDTH-1:0] exp_id_q, exp_id_d;
  logic                     underflow_q, underflow_d;

  logic [COUNTER_WIDTH-1:0] tid;
  logic [COUNTER_WIDTH-1:0] max_id;
  logic [ACC_WIDTH-1:0]     acc_in;
  logic [ACC_WIDTH-1:0]     acc_sum;
  logic [TOTAL_WIDTH-1:0]   merged;
  logic                     is_final;
  logic                     can_load;
  logic                     consume;

  assign tid    = data_in[OFFSET +: COUNTER_WIDTH];
  assign acc_in = data_in[ACC_OFFSET +: ACC_WIDTH];

  generate
    if (HAS_LITERAL_MAX_THREAD_ID != 0) begin : g_lit_max
      assign max_id = COUNTER_WIDTH'(LITERAL_MAX_THREAD_ID);
    end else begin : g_dyn_max
      assign max_id = data_in[MAX_OFFSET +: COUNTER_WIDTH];
    end
  endgenerate

  assign is_final = (tid == max_id);
  assign acc_sum  = acc_q + acc_in;
  assign can_load = !out_valid_q || rden_in;
  // Only final entries wait on the output register; gating by rst keeps rden_out low in reset.
  assign consume  = rst && !empty_in && (!is_final || can_load);

  always_comb begin
    merged = data_in;
    merged[ACC_OFFSET +: ACC_WIDTH] = acc_sum;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    acc_d       = acc_q;
    exp_id_d    = exp_id_q;
    underflow_d = underflow_q || (rden_in && !out_valid_q);
    if (rden_in && out_valid_q) begin
      out_valid_d = 1'b0;
    end
    if (consume) begin
      if (is_final) begin
        out_data_d  = merged;
        out_valid_d = 1'b1;
        acc_d       = '0;
        exp_id_d    = '0;
      end else begin
        acc_d    = acc_sum;
        exp_id_d = exp_id_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      acc_q       <= '0;
      exp_id_q    <= '0;
      underflow_q <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      acc_q       <= acc_d;
      exp_id_q    <= exp_id_d;
      underflow_q <= underflow_d;
    end
  end

  assign rden_out      = consume;
  assign data_out      = out_data_q;
  assign empty_out     = !out_valid_q;
  assign underflow_out = underflow_q;

`ifdef KANAGAWA_LOOP_COLLECTOR_SEQ_CHECK_EN
  logic seq_err_q, seq_err_d;

  always_comb begin
    seq_err_d = seq_err_q || (consume && ((tid != exp_id_q) || (tid > max_id)));
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      seq_err_q <= 1'b0;
    end else begin
      seq_err_q <= seq_err_d;
    end
  end

  assign seq_error_out = seq_err_q;
`else
  assign seq_error_out = 1'b0;
`endif

endmodule

// File: tb/tb_kanagawa_loop_collector.sv
// Directed bench for kanagawa_loop_collector: a literal-max instance (ACC 8 bits) and a
// dynamic-max instance (ACC 4 bits), with expected collapsed entries queued per instance.
module tb_kanagawa_loop_collector;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // literal-max instance: tid[3:0], payload[7:4], acc[15:8]
  logic        l_empty_in, l_rden_out, l_empty_out, l_rden_in, l_seq, l_uf;
  logic [15:0] l_data_in, l_data_out;
  // dynamic-max instance: tid[3:0], max[7:4], acc[11:8], payload[15:12]
  logic        d_empty_in, d_rden_out, d_empty_out, d_rden_in, d_seq, d_uf;
  logic [15:0] d_data_in, d_data_out;

  kanagawa_loop_collector #(
    .TOTAL_WIDTH(16), .COUNTER_WIDTH(4), .HAS_LITERAL_MAX_THREAD_ID(1),
    .LITERAL_MAX_THREAD_ID(3), .OFFSET(0), .MAX_OFFSET(4), .ACC_OFFSET(8), .ACC_WIDTH(8)
  ) u_lit (
    .clk(clk), .rst(rst), .empty_in(l_empty_in), .data_in(l_data_in), .rden_out(l_rden_out),
    .data_out(l_data_out), .empty_out(l_empty_out), .rden_in(l_rden_in),
    .seq_error_out(l_seq), .underflow_out(l_uf)
  );

  kanagawa_loop_collector #(
    .TOTAL_WIDTH(16), .COUNTER_WIDTH(4), .HAS_LITERAL_MAX_THREAD_ID(0),
    .LITERAL_MAX_THREAD_ID(0), .OFFSET(0), .MAX_OFFSET(4), .ACC_OFFSET(8), .ACC_WIDTH(4)
  ) u_dyn (
    .clk(clk), .rst(rst), .empty_in(d_empty_in), .data_in(d_data_in), .rden_out(d_rden_out),
    .data_out(d_data_out), .empty_out(d_empty_out), .rden_in(d_rden_in),
    .seq_error_out(d_seq), .underflow_out(d_uf)
  );

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [15:0] l_sb[$];
  logic [15:0] d_sb[$];
  logic        seq_exp;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pop_l(input string tag);
    if (l_sb.size() == 0) begin
      checks++; failures++;
      $error("FAIL %s observed=scoreboard_empty expected=entry", tag);
    end else chk(tag, l_data_out, l_sb.pop_front());
  endtask

  task automatic chk_pop_d(input string tag);
    if (d_sb.size() == 0) begin
      checks++; failures++;
      $error("FAIL %s observed=scoreboard_empty expected=entry", tag);
    end else chk(tag, d_data_out, d_sb.pop_front());
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] lent(input int unsigned pay, input int unsigned acc, input int unsigned tid);
    return {8'(acc), 4'(pay), 4'(tid)};
  endfunction

  function automatic logic [15:0] dent(input int unsigned pay, input int unsigned acc,
                                       input int unsigned mx, input int unsigned tid);
    return {4'(pay), 4'(acc), 4'(mx), 4'(tid)};
  endfunction

  initial begin
`ifdef KANAGAWA_LOOP_COLLECTOR_SEQ_CHECK_EN
    seq_exp = 1'b1;
`else
    seq_exp = 1'b0;
`endif
    rst = 1'b0;
    l_empty_in = 1'b0; l_data_in = lent(0, 1, 3); l_rden_in = 1'b0;
    d_empty_in = 1'b1; d_data_in = '0;            d_rden_in = 1'b0;
    step();
    #1 chk("rden_out_in_reset", 16'(l_rden_out), 16'd0);
    step();
    l_empty_in = 1'b1;
    rst = 1'b1;
    #1;
    chk("rst_l_empty", 16'(l_empty_out), 16'd1);
    chk("rst_l_data", l_data_out, 16'h0);
    chk("rst_d_empty", 16'(d_empty_out), 16'd1);
    chk("rst_d_seq", 16'(d_seq), 16'd0);
    chk("rst_d_uf", 16'(d_uf), 16'd0);

    // literal max=3, four threads, downstream reading every cycle
    l_rden_in = 1'b1;
    for (int unsigned i = 0; i < 4; i++) begin
      step();
      chk("lit_empty_before_final", 16'(l_empty_out), 16'd1);
      l_empty_in = 1'b0;
      l_data_in  = lent((i == 3) ? 5 : 0, i + 1, i);
      #1 chk("lit_rden_out", 16'(l_rden_out), 16'd1);
      if (i == 3) l_sb.push_back(lent(5, 10, 3));
    end
    step();
    l_empty_in = 1'b1;
    chk("lit_out_valid", 16'(l_empty_out), 16'd0);
    chk_pop_l("lit_out_acc10");
    step();
    l_rden_in = 1'b0;
    chk("lit_single_output", 16'(l_empty_out), 16'd1);
    chk("lit_uf_from_early_reads", 16'(l_uf), 16'd1);

    // dynamic max, single-thread call
    step();
    d_empty_in = 1'b0; d_data_in = dent(4'hA, 7, 0, 0);
    #1 chk("single_rden_out", 16'(d_rden_out), 16'd1);
    d_sb.push_back(dent(4'hA, 7, 0, 0));
    step();
    d_empty_in = 1'b1;
    chk("single_latency", 16'(d_empty_out), 16'd0);
    chk_pop_d("single_acc7");
    d_rden_in = 1'b1;
    step();
    d_rden_in = 1'b0;
    chk("single_drained", 16'(d_empty_out), 16'd1);
    chk("single_no_uf", 16'(d_uf), 16'd0);
    chk("single_no_seq", 16'(d_seq), 16'd0);

    // ACC wrap-around, two threads of 9 in a 4-bit field; output left held
    d_empty_in = 1'b0; d_data_in = dent(0, 9, 1, 0);
    step();
    d_data_in = dent(4'hB, 9, 1, 1);
    d_sb.push_back(dent(4'hB, 2, 1, 1));
    step();
    d_empty_in = 1'b1;
    chk("wrap_valid", 16'(d_empty_out), 16'd0);
    chk("wrap_acc2", d_data_out, d_sb[0]);

    // held output: non-final threads flow, final entry stalls until read
    d_empty_in = 1'b0; d_data_in = dent(0, 1, 2, 0);
    #1 chk("hold_nonfinal0_rden", 16'(d_rden_out), 16'd1);
    step();
    d_data_in = dent(0, 2, 2, 1);
    #1 chk("hold_nonfinal1_rden", 16'(d_rden_out), 16'd1);
    step();
    d_data_in = dent(4'hC, 3, 2, 2);
    #1 chk("hold_final_stalled", 16'(d_rden_out), 16'd0);
    step();
    chk("hold_still_stalled", 16'(d_rden_out), 16'd0);
    chk("hold_still_valid", 16'(d_empty_out), 16'd0);
    d_rden_in = 1'b1;
    #1 chk("hold_release_rden", 16'(d_rden_out), 16'd1);
    chk_pop_d("hold_old_entry");
    d_sb.push_back(dent(4'hC, 6, 2, 2));
    step();
    d_empty_in = 1'b1; d_rden_in = 1'b0;
    chk("b2b_still_valid", 16'(d_empty_out), 16'd0);
    chk_pop_d("b2b_new_acc6");
    d_rden_in = 1'b1;
    step();
    d_rden_in = 1'b0;
    chk("b2b_drained", 16'(d_empty_out), 16'd1);

    // thread-order error: tid 0 then 2 under max=2
    d_empty_in = 1'b0; d_data_in = dent(0, 1, 2, 0);
    step();
    chk("seq_ok_after_tid0", 16'(d_seq), 16'd0);
    d_data_in = dent(4'hD, 1, 2, 2);
    d_sb.push_back(dent(4'hD, 2, 2, 2));
    step();
    d_empty_in = 1'b1;
    chk("seq_after_tid2", 16'(d_seq), 16'(seq_exp));
    chk_pop_d("seq_data_unaffected");
    d_rden_in = 1'b1;
    step();
    d_rden_in = 1'b0;
    step();
    chk("seq_sticky", 16'(d_seq), 16'(seq_exp));

    // underflow: read while empty
    chk("uf_before", 16'(d_uf), 16'd0);
    d_rden_in = 1'b1;
    step();
    d_rden_in = 1'b0;
    chk("uf_set", 16'(d_uf), 16'd1);
    chk("uf_state_kept", 16'(d_empty_out), 16'd1);
    step();
    chk("uf_sticky", 16'(d_uf), 16'd1);

    // reset mid-call discards partial accumulation
    l_empty_in = 1'b0; l_data_in = lent(0, 5, 0);
    step();
    l_empty_in = 1'b1;
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("reset_clears_uf", 16'(d_uf), 16'd0);
    chk("reset_clears_seq", 16'(d_seq), 16'd0);
    chk("reset_l_empty", 16'(l_empty_out), 16'd1);
    for (int unsigned i = 0; i < 4; i++) begin
      l_empty_in = 1'b0;
      l_data_in  = lent((i == 3) ? 6 : 0, i + 1, i);
      step();
    end
    l_sb.push_back(lent(6, 10, 3));
    l_empty_in = 1'b1;
    chk("post_reset_valid", 16'(l_empty_out), 16'd0);
    chk_pop_l("post_reset_acc10");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
